// File: rtl/fp_mul_issue.sv
// Operand-issue stage ahead of the FP32 multiplier: FIFO, classify, bypass specials.
// Latency: bypass/mul_start one cycle after the head pops; mul_start spaced >= ISSUE_GAP cycles.
// Backpressure: in_ready drops when the FIFO is full; the head waits while the multiplier is busy.
module fp_mul_issue #(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 4,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              mul_a,
    output logic [31:0]              mul_b,
    output logic                     mul_start,
    output logic [TAG_W-1:0]         mul_tag,
    output logic                     bypass_valid,
    output logic [31:0]              bypass_result,
    output logic [TAG_W-1:0]         bypass_tag,
    output logic                     bypass_invalid,
    output logic [5:0]               cls_a,
    output logic [5:0]               cls_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(ISSUE_GAP) + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // One-hot: [0] zero, [1] subnormal, [2] normal, [3] inf, [4] qNaN, [5] sNaN
    function automatic logic [5:0] classify(input logic [31:0] x);
        logic [5:0] c;
        c = '0;
        if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) c[0] = 1'b1;
            else                  c[1] = 1'b1;
        end else if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) c[3] = 1'b1;
            else if (x[22])       c[4] = 1'b1;
            else                  c[5] = 1'b1;
        end else begin
            c[2] = 1'b1;
        end
        return c;
    endfunction

    logic [31:0]      mem_a_q   [DEPTH];
    logic [31:0]      mem_b_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [TAG_W-1:0] mul_tag_q, mul_tag_d;
    logic             mul_start_q, mul_start_d;
    logic             byp_vld_q, byp_vld_d;
    logic [31:0]      byp_res_q, byp_res_d;
    logic [TAG_W-1:0] byp_tag_q, byp_tag_d;
    logic             byp_inv_q, byp_inv_d;

    logic             push, pop, head_vld, head_special;
    logic [31:0]      head_a, head_b;
    logic [TAG_W-1:0] head_tag;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_any, sign;
    logic [31:0]      res_c;
    logic             inv_c;

    assign in_ready = reset && (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head_vld = (count_q != '0);
    assign pop      = (state_q == S_IDLE) && head_vld;

    assign head_a   = mem_a_q[rd_ptr_q];
    assign head_b   = mem_b_q[rd_ptr_q];
    assign head_tag = mem_tag_q[rd_ptr_q];

    assign cls_a = head_vld ? classify(head_a) : 6'd0;
    assign cls_b = head_vld ? classify(head_b) : 6'd0;

    assign zero_a   = cls_a[0];
    assign zero_b   = cls_b[0];
    assign inf_a    = cls_a[3];
    assign inf_b    = cls_b[3];
    assign nan_a    = cls_a[4] | cls_a[5];
    assign nan_b    = cls_b[4] | cls_b[5];
    assign snan_any = cls_a[5] | cls_b[5];
    assign sign     = head_a[31] ^ head_b[31];
    assign head_special = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;

    // NaN dominates, then inf*zero, then inf, then zero.
    always_comb begin
        res_c = {sign, 31'd0};
        inv_c = 1'b0;
        if (nan_a || nan_b) begin
            res_c = QNAN;
            inv_c = snan_any;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            res_c = QNAN;
            inv_c = 1'b1;
        end else if (inf_a || inf_b) begin
            res_c = {sign, 8'hFF, 23'd0};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        gap_d       = gap_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_tag_d   = mul_tag_q;
        mul_start_d = 1'b0;
        byp_vld_d   = 1'b0;
        byp_res_d   = byp_res_q;
        byp_tag_d   = byp_tag_q;
        byp_inv_d   = byp_inv_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_special) begin
                        byp_vld_d = 1'b1;
                        byp_res_d = res_c;
                        byp_tag_d = head_tag;
                        byp_inv_d = inv_c;
                    end else begin
                        mul_a_d     = head_a;
                        mul_b_d     = head_b;
                        mul_tag_d   = head_tag;
                        mul_start_d = 1'b1;
                        gap_d       = GW'(ISSUE_GAP - 1);
                        if (ISSUE_GAP > 1) state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Leaving on the cycle the counter reaches zero keeps starts exactly ISSUE_GAP apart.
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]   <= in_a;
            mem_b_q[wr_ptr_q]   <= in_b;
            mem_tag_q[wr_ptr_q] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            gap_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_tag_q   <= '0;
            mul_start_q <= 1'b0;
            byp_vld_q   <= 1'b0;
            byp_res_q   <= '0;
            byp_tag_q   <= '0;
            byp_inv_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_tag_q   <= mul_tag_d;
            mul_start_q <= mul_start_d;
            byp_vld_q   <= byp_vld_d;
            byp_res_q   <= byp_res_d;
            byp_tag_q   <= byp_tag_d;
            byp_inv_q   <= byp_inv_d;
        end
    end

    assign mul_a          = mul_a_q;
    assign mul_b          = mul_b_q;
    assign mul_tag        = mul_tag_q;
    assign mul_start      = mul_start_q;
    assign bypass_valid   = byp_vld_q;
    assign bypass_result  = byp_res_q;
    assign bypass_tag     = byp_tag_q;
    assign bypass_invalid = byp_inv_q;
    assign count          = count_q;
    assign busy           = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_fp_mul_issue.sv
// Scoreboard bench for fp_mul_issue: directed operand pairs with hand-computed results.
module tb_fp_mul_issue;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int TW    = 4;

    typedef struct {
        logic        is_mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic [31:0] mul_a, mul_b, bypass_result;
    logic        mul_start, bypass_valid, bypass_invalid, busy;
    logic [3:0]  mul_tag, bypass_tag;
    logic [5:0]  cls_a, cls_b;
    logic [2:0]  count;

    fp_mul_issue #(.DEPTH(DEPTH), .ISSUE_GAP(GAP), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_tag(mul_tag),
        .bypass_valid(bypass_valid), .bypass_result(bypass_result),
        .bypass_tag(bypass_tag), .bypass_invalid(bypass_invalid),
        .cls_a(cls_a), .cls_b(cls_b), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   last_start = -1000;
    int   start_cyc [16];
    logic saw_full = 1'b0;
    exp_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (mul_start || bypass_valid) begin
                chk("exclusive_outputs", 32'(mul_start && bypass_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got start=%0b bypass=%0b required none", mul_start, bypass_valid);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    chk("kind_is_mul", 32'(mul_start), 32'(e.is_mul));
                    if (mul_start) begin
                        chk("mul_a", mul_a, e.a);
                        chk("mul_b", mul_b, e.b);
                        chk("mul_tag", 32'(mul_tag), 32'(e.tag));
                        chk("issue_gap_min", 32'((cyc - last_start) >= GAP), 32'd1);
                        last_start = cyc;
                        start_cyc[mul_tag] = cyc;
                    end else begin
                        chk("bypass_result", bypass_result, e.a);
                        chk("bypass_tag", 32'(bypass_tag), 32'(e.tag));
                        chk("bypass_invalid", 32'(bypass_invalid), 32'(e.inv));
                    end
                end
            end
            chk("count", 32'(count), 32'(n_acc - n_out));
            chk("in_ready", 32'(in_ready), 32'(count < 3'(DEPTH)));
            if (count != 0) chk("busy_nonempty", 32'(busy), 32'd1);
            if (count == 3'(DEPTH) && !in_ready) saw_full = 1'b1;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        input logic is_mul, input logic [31:0] r, input logic inv);
        int   n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL push_timeout tag=%0d: got in_ready=0 required 1", t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.is_mul = is_mul;
        e.a      = is_mul ? a : r;
        e.b      = b;
        e.tag    = t;
        e.inv    = inv;
        exp_q.push_back(e);
        n_acc++;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (GAP + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_mul_start", 32'(mul_start), 32'd0);
            chk("rst_bypass_valid", 32'(bypass_valid), 32'd0);
        end
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_bypass_result", bypass_result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("empty_cls_a", 32'(cls_a), 32'd0);
        chk("empty_cls_b", 32'(cls_b), 32'd0);

        // Two normal pairs back to back: second start exactly GAP cycles later.
        push(32'h3F800000, 32'h40000000, 4'd1, 1'b1, 32'h0, 1'b0);
        push(32'h40400000, 32'h40800000, 4'd2, 1'b1, 32'h0, 1'b0);
        drain();
        chk("issue_cadence", 32'(start_cyc[2] - start_cyc[1]), 32'(GAP));
        chk("idle_busy", 32'(busy), 32'd0);

        // Special operands resolved on the bypass port; subnormal goes to the multiplier.
        push(32'h7F800000, 32'h00000000, 4'd3,  1'b0, 32'h7FC00000, 1'b1);
        push(32'hFF800000, 32'h40000000, 4'd4,  1'b0, 32'hFF800000, 1'b0);
        push(32'h7F800001, 32'h3F800000, 4'd5,  1'b0, 32'h7FC00000, 1'b1);
        push(32'h80000000, 32'h3F800000, 4'd6,  1'b0, 32'h80000000, 1'b0);
        push(32'h00000001, 32'h3F800000, 4'd7,  1'b1, 32'h0,        1'b0);
        push(32'h7FC00000, 32'h00000000, 4'd8,  1'b0, 32'h7FC00000, 1'b0);
        push(32'h00000000, 32'hFF800000, 4'd9,  1'b0, 32'h7FC00000, 1'b1);
        push(32'h80000000, 32'h80000000, 4'd10, 1'b0, 32'h00000000, 1'b0);
        push(32'hFF800000, 32'hBF800000, 4'd11, 1'b0, 32'h7F800000, 1'b0);
        drain();

        // Fill behind a multiply, then bypasses drain while pushes continue at count=DEPTH-1.
        saw_full = 1'b0;
        push(32'h3F800000, 32'h3F800000, 4'd1, 1'b1, 32'h0, 1'b0);
        for (int i = 2; i < 8; i++)
            push(32'h00000000, 32'h3F800000, 4'(i), 1'b0, 32'h00000000, 1'b0);
        drain();
        chk("fill1_full_seen", 32'(saw_full), 32'd1);

        // Second fill with all normals: multiplier cadence stalls the queue.
        saw_full = 1'b0;
        for (int i = 8; i < 14; i++)
            push(32'h3F800000 + 32'(i), 32'h40000000, 4'(i), 1'b1, 32'h0, 1'b0);
        drain();
        chk("fill2_full_seen", 32'(saw_full), 32'd1);

        // Reset while in WAIT with two pairs queued.
        push(32'h3F800000, 32'h3F800000, 4'd1, 1'b1, 32'h0, 1'b0);
        push(32'h00000001, 32'h7F800001, 4'd2, 1'b0, 32'h7FC00000, 1'b1);
        push(32'h3F800000, 32'h40000000, 4'd3, 1'b1, 32'h0, 1'b0);
        chk("wait_count", 32'(count), 32'd2);
        chk("head_cls_a_subnormal", 32'(cls_a), 32'h02);
        chk("head_cls_b_snan", 32'(cls_b), 32'h20);
        reset = 1'b0;
        #1;
        exp_q.delete();
        n_acc = n_out;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_mul_start", 32'(mul_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        push(32'h3F800000, 32'hBF800000, 4'd14, 1'b1, 32'h0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
